// File: rtl/alien_fleet_controller_if.sv
// Control/status bundle between the fleet sequencer and the game logic.
// The game side drives the request/event signals; the sequencer drives the fleet controls.
interface alien_fleet_controller_if #(
    parameter int NUM_ALIENS = 40
);
    localparam int AW = $clog2(NUM_ALIENS + 1);

    logic          startOfFrame;
    logic          gameStart;
    logic          levelRestart;
    logic          edgeHitLeft;
    logic          edgeHitRight;
    logic          alienKilled;
    logic          invadersLanded;

    logic          Y_direction;
    logic          toggleX;
    logic          stepPulse;
    logic          dirRight;
    logic [AW-1:0] aliveCount;
    logic          fleetCleared;
    logic          fleetLanded;

    modport master (
        output startOfFrame, gameStart, levelRestart, edgeHitLeft, edgeHitRight,
               alienKilled, invadersLanded,
        input  Y_direction, toggleX, stepPulse, dirRight, aliveCount,
               fleetCleared, fleetLanded
    );

    modport slave (
        input  startOfFrame, gameStart, levelRestart, edgeHitLeft, edgeHitRight,
               alienKilled, invadersLanded,
        output Y_direction, toggleX, stepPulse, dirRight, aliveCount,
               fleetCleared, fleetLanded
    );
endinterface

// File: rtl/alien_fleet_controller.sv
// Invader formation sequencer: march cadence, edge descend/reverse, clear and landing tracking.
// Optional FLEET_SPEEDUP_EN shortens the march period as the surviving-alien count drops.
module alien_fleet_controller #(
    parameter int NUM_ALIENS     = 40,
    parameter int BASE_PERIOD    = 32,
    parameter int MIN_PERIOD     = 2,
    parameter int SPEED_SHIFT    = 1,
    parameter int DESCEND_FRAMES = 8
) (
    input  logic                    clk,
    input  logic                    resetN,
    alien_fleet_controller_if.slave bus
);
    localparam int AW = $clog2(NUM_ALIENS + 1);
    localparam int PW = $clog2(BASE_PERIOD + 1);
    localparam int DW = $clog2(DESCEND_FRAMES + 1);

    if (MIN_PERIOD < 1 || MIN_PERIOD > BASE_PERIOD || SPEED_SHIFT < 0 || DESCEND_FRAMES < 1)
    begin : g_bad_config
        $error("alien_fleet_controller: inconsistent period/descend parameters");
    end

    typedef enum logic [2:0] {
        IDLE,
        MARCH,
        DESCEND,
        REVERSE,
        CLEARED,
        LANDED
    } state_t;

    state_t        state, state_nx;
    logic [PW-1:0] frame_cnt, frame_cnt_nx;
    logic [DW-1:0] desc_cnt, desc_cnt_nx;
    logic [PW-1:0] period;
    logic [PW:0]   cnt_plus;
    logic          step_due;
    logic          desc_last;
    logic          edge_trig;

    logic          y_nx;
    logic          toggle_nx;
    logic          step_nx;
    logic          dir_nx;
    logic [AW-1:0] alive_nx;
    logic          cleared_nx;
    logic          landed_nx;

`ifdef FLEET_SPEEDUP_EN
    localparam int SW = ((AW > PW) ? AW : PW) + 1;
    logic [SW-1:0] scaled;

    always_comb begin
        scaled = SW'(MIN_PERIOD) + SW'(bus.aliveCount >> SPEED_SHIFT);
        period = (scaled > SW'(BASE_PERIOD)) ? PW'(BASE_PERIOD) : scaled[PW-1:0];
    end
`else
    assign period = PW'(BASE_PERIOD);
`endif

    // counter+1 >= period is the same test as counter >= period-1, without underflow
    assign cnt_plus  = {1'b0, frame_cnt} + (PW + 1)'(1);
    assign step_due  = (cnt_plus >= {1'b0, period});
    assign desc_last = (desc_cnt == DW'(DESCEND_FRAMES - 1));
    assign edge_trig = (bus.dirRight & bus.edgeHitRight) | (~bus.dirRight & bus.edgeHitLeft);

    always_comb begin
        state_nx     = state;
        frame_cnt_nx = frame_cnt;
        desc_cnt_nx  = desc_cnt;
        y_nx         = bus.Y_direction;
        toggle_nx    = 1'b0;
        step_nx      = 1'b0;
        dir_nx       = bus.dirRight;
        alive_nx     = bus.aliveCount;
        cleared_nx   = bus.fleetCleared;
        landed_nx    = bus.fleetLanded;

        if (state != IDLE && bus.alienKilled && bus.aliveCount != '0) begin
            alive_nx = bus.aliveCount - AW'(1);
        end

        case (state)
            IDLE: begin
                if (bus.gameStart) begin
                    state_nx = MARCH;
                end
            end

            MARCH, DESCEND, REVERSE: begin
                // landing beats clearing, which beats any movement in the same cycle
                if (bus.invadersLanded) begin
                    state_nx  = LANDED;
                    landed_nx = 1'b1;
                    y_nx      = 1'b0;
                end else if (alive_nx == '0) begin
                    state_nx   = CLEARED;
                    cleared_nx = 1'b1;
                    y_nx       = 1'b0;
                end else begin
                    case (state)
                        MARCH: begin
                            if (edge_trig) begin
                                state_nx    = DESCEND;
                                desc_cnt_nx = '0;
                                y_nx        = 1'b1;
                            end else if (bus.startOfFrame) begin
                                if (step_due) begin
                                    frame_cnt_nx = '0;
                                    step_nx      = 1'b1;
                                end else begin
                                    frame_cnt_nx = frame_cnt + PW'(1);
                                end
                            end
                        end
                        DESCEND: begin
                            if (bus.startOfFrame) begin
                                if (desc_last) begin
                                    state_nx     = REVERSE;
                                    desc_cnt_nx  = '0;
                                    y_nx         = 1'b0;
                                    toggle_nx    = 1'b1;
                                    dir_nx       = ~bus.dirRight;
                                    frame_cnt_nx = '0;
                                end else begin
                                    desc_cnt_nx = desc_cnt + DW'(1);
                                end
                            end
                        end
                        default: begin
                            state_nx = MARCH;
                        end
                    endcase
                end
            end

            CLEARED, LANDED: begin
                state_nx = state;
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN || bus.levelRestart) begin
            state            <= IDLE;
            frame_cnt        <= '0;
            desc_cnt         <= '0;
            bus.Y_direction  <= 1'b0;
            bus.toggleX      <= 1'b0;
            bus.stepPulse    <= 1'b0;
            bus.dirRight     <= 1'b1;
            bus.aliveCount   <= AW'(NUM_ALIENS);
            bus.fleetCleared <= 1'b0;
            bus.fleetLanded  <= 1'b0;
        end else begin
            state            <= state_nx;
            frame_cnt        <= frame_cnt_nx;
            desc_cnt         <= desc_cnt_nx;
            bus.Y_direction  <= y_nx;
            bus.toggleX      <= toggle_nx;
            bus.stepPulse    <= step_nx;
            bus.dirRight     <= dir_nx;
            bus.aliveCount   <= alive_nx;
            bus.fleetCleared <= cleared_nx;
            bus.fleetLanded  <= landed_nx;
        end
    end
endmodule

// File: doc/alien_fleet_controller.md
Name: alien_fleet_controller

Overview:
- Upstream sequencer for the invader formation; sits directly before every alien block.
- Drives the shared Y_direction (descend) and toggleX (reverse) controls, plus a per-step move strobe.
- Decides march cadence from frame count and surviving-alien count, reacts to aggregated edge hits, and tracks the cleared and landed conditions for the game controller.

Parameters:
- NUM_ALIENS, 40: aliens at level start; width of aliveCount is clog2(NUM_ALIENS+1).
- BASE_PERIOD, 32: frames per march step (maximum period).
- MIN_PERIOD, 2: floor of the march period, in frames.
- SPEED_SHIFT, 1: alive-count divisor (right shift) used by the speed-up formula.
- DESCEND_FRAMES, 8: frames Y_direction stays high per edge event.

Ports:
- clk  in  1  system clock.
- resetN  in  1  synchronous active-low reset.
- startOfFrame  in  1  one-cycle pulse per video frame.
- gameStart  in  1  pulse; leaves IDLE.
- levelRestart  in  1  pulse; synchronous re-init to reset values.
- edgeHitLeft  in  1  OR of all alien left-edge hit codes.
- edgeHitRight  in  1  OR of all alien right-edge hit codes.
- alienKilled  in  1  one-cycle pulse per destroyed alien.
- invadersLanded  in  1  any alien reached the player row.
- Y_direction  out  1  high = fleet moving down.
- toggleX  out  1  one-cycle pulse = reverse horizontal direction.
- stepPulse  out  1  one-cycle march strobe.
- dirRight  out  1  current horizontal direction; 1 = right.
- aliveCount  out  clog2(NUM_ALIENS+1)  surviving aliens.
- fleetCleared  out  1  level cleared, sticky.
- fleetLanded  out  1  invasion succeeded, sticky.

Behaviour:
- Clock and reset: single clock clk. Reset is resetN, synchronous, active-low; all state updates only on the rising edge of clk.
- Reset values: state IDLE, Y_direction 0, toggleX 0, stepPulse 0, dirRight 1, aliveCount NUM_ALIENS, fleetCleared 0, fleetLanded 0, frame counter 0, descend counter 0.
- Priority: resetN > levelRestart > all other inputs. levelRestart restores exactly the reset values.
- All outputs are registered.

States:
- IDLE: outputs held at reset values; gameStart -> MARCH.
- MARCH: frame counter increments on each startOfFrame. When a startOfFrame arrives with counter >= period-1:
  - counter clears to 0;
  - stepPulse is high for the following cycle only.
  - Use >= so a period that shrinks mid-count fires at once.
- Edge trigger in MARCH: (dirRight & edgeHitRight) | (!dirRight & edgeHitLeft) -> DESCEND next cycle.
  - Y_direction rises on DESCEND entry.
  - Edge hits opposite to dirRight are ignored.
- DESCEND:
  - Y_direction = 1 and stepPulse is suppressed.
  - Descend counter counts startOfFrame; after DESCEND_FRAMES pulses -> REVERSE.
  - Edge inputs are ignored.
- REVERSE (1 cycle):
  - toggleX = 1, dirRight inverts, Y_direction = 0, frame counter clears.
  - -> MARCH.
- CLEARED: fleetCleared = 1, Y_direction = 0, no strobes. Left only by levelRestart or reset.
- LANDED: fleetLanded = 1, Y_direction = 0, no strobes. Left only by levelRestart or reset.

Alive count:
- alienKilled decrements aliveCount in every state except IDLE; it saturates at 0.
- The transition to 0 -> CLEARED next cycle, from MARCH/DESCEND/REVERSE.
- A kill together with an edge event: both take effect (decrement plus DESCEND entry). If the count reaches 0 in that cycle, CLEARED wins over DESCEND.

Landing:
- invadersLanded in MARCH/DESCEND/REVERSE -> LANDED.
- A kill that empties the fleet in the same cycle as invadersLanded: LANDED wins, and the decrement still applies.

Period:
- Computed combinationally from the current aliveCount (see Optional Feature).
- Width of the period and frame counter is clog2(BASE_PERIOD+1).

Optional Feature:
- Macro: FLEET_SPEEDUP_EN.
- Defined: period = min(BASE_PERIOD, MIN_PERIOD + (aliveCount >> SPEED_SHIFT)). With defaults, 40 alive -> 22 frames, 1 alive -> 2 frames.
- Undefined: period = BASE_PERIOD constant; speed-up logic absent.
- All other behaviour is identical in both builds.

Test Plan:
- Reset/idle: hold resetN=0, pulse startOfFrame x5, then release without gameStart -> all outputs at reset values, aliveCount=40, no stepPulse.
- March cadence, macro undefined: gameStart, then 64 startOfFrame pulses -> exactly 2 stepPulse, each one cycle wide, one cycle after the 32nd and 64th frame pulses.
- Edge reversal: in MARCH with dirRight=1, raise edgeHitRight -> Y_direction high next cycle for 8 frames; then toggleX is a single-cycle pulse, dirRight=0; edgeHitRight held high afterwards causes no second DESCEND.
- Speed-up, macro defined: kill 38 aliens (aliveCount=2) -> steps every 3 frames; kill one more (aliveCount=1) -> steps every 2 frames.
- Clear vs land: alienKilled and invadersLanded in the same cycle with aliveCount=1 -> LANDED, fleetLanded=1, fleetCleared=0, aliveCount=0.
- Clear and restart: kill all 40 -> fleetCleared=1; then levelRestart -> aliveCount=40, state IDLE, fleetCleared=0, dirRight=1.
